// File: rtl/booth_seq_mult.sv
// ============================================================================
// booth_seq_mult
// Sequential radix-4 Booth multiplier with a valid/ready handshake on both
// the operand side and the product side.
//
// Both operands are extended to DATA_WIDTH+2 bits. The extension is a sign
// extension when signed_i=1 and a zero extension otherwise. The multiplier
// then yields N = DATA_WIDTH/2+1 Booth digits. PP_PER_CYCLE digits are
// retired on each BUSY edge, so a product takes C = ceil(N/PP_PER_CYCLE)
// edges.
//
// Optional feature: define BOOTH_SEQ_EARLY_TERM_EN to finish as soon as the
// multiplier bits still unprocessed (including the overlap bit) are all 0 or
// all 1. The remaining digits are then all zero and cannot change the result.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_n_i      : asynchronous active-low reset
//   flush_i      : synchronous abort; forces IDLE and discards any result
//   in_valid_i   : operands valid
//   in_ready_o   : block accepts operands
//   signed_i     : 1 = two's-complement operands, 0 = unsigned
//   a_i          : multiplicand, DATA_WIDTH bits
//   b_i          : multiplier (Booth-recoded), DATA_WIDTH bits
//   out_valid_o  : product valid
//   out_ready_i  : consumer takes the product
//   p_o          : product, 2*DATA_WIDTH bits
// ============================================================================
module booth_seq_mult #(
    parameter int DATA_WIDTH   = 16,
    parameter int PP_PER_CYCLE = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    signed_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [2*DATA_WIDTH-1:0] p_o
);

    localparam int N_DIGITS = DATA_WIDTH / 2 + 1;
    localparam int N_CYCLES = (N_DIGITS + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
    // The extra headroom beyond 2*DATA_WIDTH+2 keeps the top partial product
    // (+-2 * A * 4^(N-1)) from wrapping.
    localparam int ACC_W    = 2 * DATA_WIDTH + 4;
    // The extended multiplier plus the b[-1] overlap bit at position 0.
    localparam int B_W      = DATA_WIDTH + 3;
    localparam int CNT_W    = $clog2(N_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [ACC_W-1:0]        acc, acc_step;
    logic [ACC_W-1:0]        m_reg, m_next;
    logic [B_W-1:0]          b_reg, b_shift;
    logic [CNT_W-1:0]        cnt;
    logic [2*DATA_WIDTH-1:0] p_reg;
    logic                    accept;
    logic                    last_step;

    logic [2:0]              trip;
    logic                    pp_neg, pp_one, pp_two;
    logic [ACC_W-1:0]        m_sh, pp_mag;

    assign in_ready_o  = (state == IDLE) || ((state == DONE) && out_ready_i);
    assign out_valid_o = (state == DONE);
    assign p_o         = p_reg;
    assign accept      = in_valid_i && in_ready_o && !flush_i;

    // The low PP_PER_CYCLE triples of b_reg are retired this edge. After that,
    // b_reg and m_reg are shifted so that the next digit is again at bit 0.
    always_comb begin
        // NOTE: every variable in this block is given a value before any branch
        // can skip it. Without that, synthesis infers a latch.
        acc_step = acc;
        trip     = '0;
        pp_neg   = 1'b0;
        pp_one   = 1'b0;
        pp_two   = 1'b0;
        m_sh     = '0;
        pp_mag   = '0;
        for (int i = 0; i < PP_PER_CYCLE; i++) begin
            trip   = b_reg[2*i +: 3];
            // 111 must recode to 0, so it is excluded from the negative digits.
            pp_neg = trip[2] & ~(trip[1] & trip[0]);
            pp_one = trip[1] ^ trip[0];
            pp_two = (trip == 3'b011) || (trip == 3'b100);
            m_sh   = m_reg << (2 * i);
            if (pp_two) begin
                pp_mag = m_sh << 1;
            end else if (pp_one) begin
                pp_mag = m_sh;
            end else begin
                pp_mag = '0;
            end
            // A negative digit is added as the one's complement of the
            // magnitude plus a carry-in of 1.
            acc_step = acc_step + (pp_neg ? ~pp_mag : pp_mag)
                     + {{(ACC_W-1){1'b0}}, pp_neg};
        end
    end

    // The arithmetic shift replicates the extension bit. This makes the
    // digits beyond N recode to zero, and it lets the early-termination test
    // check the whole register.
    assign b_shift = $signed(b_reg) >>> (2 * PP_PER_CYCLE);
    assign m_next  = m_reg << (2 * PP_PER_CYCLE);

`ifdef BOOTH_SEQ_EARLY_TERM_EN
    assign last_step = (cnt == CNT_W'(N_CYCLES - 1)) || (&b_shift) || (~|b_shift);
`else
    assign last_step = (cnt == CNT_W'(N_CYCLES - 1));
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (last_step) state_next = DONE;
            DONE: begin
                if (accept) begin
                    state_next = BUSY;
                end else if (out_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush_i) begin
            state_next = IDLE;
        end
    end

    // NOTE: state registers use non-blocking assignments. This way every
    // flop samples the values from before the edge, whatever the order of
    // the statements.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc   <= '0;
            m_reg <= '0;
            b_reg <= '0;
            cnt   <= '0;
            p_reg <= '0;
        end else if (accept) begin
            acc   <= '0;
            m_reg <= {{(ACC_W-DATA_WIDTH){signed_i & a_i[DATA_WIDTH-1]}}, a_i};
            b_reg <= {{2{signed_i & b_i[DATA_WIDTH-1]}}, b_i, 1'b0};
            cnt   <= '0;
        end else if (state == BUSY && !flush_i) begin
            acc   <= acc_step;
            m_reg <= m_next;
            b_reg <= b_shift;
            cnt   <= cnt + CNT_W'(1);
            if (last_step) begin
                p_reg <= acc_step[2*DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
module tb_booth_seq_mult;

    localparam int W = 8;
    localparam int C = 5;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic          signed_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [2*W-1:0] p_o;

    int tests_run = 0;
    int fails     = 0;

    booth_seq_mult #(.DATA_WIDTH(W), .PP_PER_CYCLE(1)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .signed_i   (signed_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .p_o        (p_o)
    );

    always #5 clk = ~clk;

    // Reference product: plain integer multiply of the extended operands, mod 2^16.
    function automatic logic [2*W-1:0] exp_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic s);
        logic [2*W-1:0] ea, eb;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Reference latency. It is C edges normally. With early termination,
    // it is the first k at which the extended-multiplier bits from 2k-1
    // up to the top are all equal.
    function automatic int exp_lat(input logic [W-1:0] b, input logic s);
`ifdef BOOTH_SEQ_EARLY_TERM_EN
        logic [W+1:0] be;
        bit           same;
        be = s ? {{2{b[W-1]}}, b} : {2'b00, b};
        for (int k = 1; k < C; k++) begin
            same = 1'b1;
            for (int j = 2*k-1; j <= W+1; j++) begin
                if (be[j] != be[2*k-1]) same = 1'b0;
            end
            if (same) return k;
        end
        return C;
`else
        return C;
`endif
    endfunction

    // Accepts one operation and then counts the edges until out_valid_o
    // (the bound is 20). It leaves the DUT in DONE. When junk=1, garbage
    // in_valid/operands are driven while the DUT is busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit junk, output int lat, output logic [2*W-1:0] p);
        a_i = a; b_i = b; signed_i = s; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = junk;
        if (junk) begin
            a_i = W'($urandom); b_i = W'($urandom); signed_i = 1'($urandom);
        end
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid_i = 1'b0;
        p = p_o;
    endtask

    task automatic consume();
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if (out_valid_o !== 1'b0 || p_o !== '0) begin
            fails++;
            $display("FAIL reset_state: out_valid=%b p=%h, want 0/0000", out_valid_o, p_o);
        end
        #10 rst_n_i = 1'b1;
        tests_run++;
        if (in_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: in_ready=%b, want 1", in_ready_o);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL reset_release_spurious: out_valid=%b cycle %0d", out_valid_o, i);
            end
        end
    endtask

    task automatic test_directed();
        logic [W-1:0]   ta [5] = '{8'h80, 8'hFF, 8'hFF, 8'h55, 8'h55};
        logic [W-1:0]   tb [5] = '{8'h80, 8'hFF, 8'hFF, 8'h01, 8'hFF};
        logic           ts [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2*W-1:0] tp [5] = '{16'h4000, 16'hFE01, 16'h0001, 16'h0055, 16'hFFAB};
        int             lat;
        logic [2*W-1:0] p;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], ts[i], 1'b0, lat, p);
            tests_run++;
            if (p !== tp[i] || lat != exp_lat(tb[i], ts[i])) begin
                fails++;
                $display("FAIL directed_%0d: p=%h lat=%0d, want p=%h lat=%0d",
                         i, p, lat, tp[i], exp_lat(tb[i], ts[i]));
            end
            consume();
        end
    endtask

    task automatic test_random();
        logic [W-1:0]   a, b;
        logic           s;
        int             lat;
        logic [2*W-1:0] p;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom); s = 1'($urandom);
            if (i % 8 == 0) b = s ? 8'hFF : 8'h00;
            run_op(a, b, s, 1'b1, lat, p);
            tests_run++;
            if (p !== exp_prod(a, b, s) || lat != exp_lat(b, s)) begin
                fails++;
                $display("FAIL random_%0d a=%h b=%h s=%b: p=%h lat=%0d, want p=%h lat=%0d",
                         i, a, b, s, p, lat, exp_prod(a, b, s), exp_lat(b, s));
            end
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int             lat;
        logic [2*W-1:0] p, held;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, lat, p);
        // Second operation is offered in the DONE cycle together with out_ready_i.
        out_ready_i = 1'b1; in_valid_i = 1'b1;
        a_i = 8'hF3; b_i = 8'h6B; signed_i = 1'b1;
        #1;
        tests_run++;
        if (in_ready_o !== 1'b1 || p !== exp_prod(8'h12, 8'h34, 1'b0)) begin
            fails++;
            $display("FAIL b2b_first: in_ready=%b p=%h, want 1/%h",
                     in_ready_o, p, exp_prod(8'h12, 8'h34, 1'b0));
        end
        @(posedge clk); #1;
        out_ready_i = 1'b0; in_valid_i = 1'b0;
        lat = 0;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run++;
        if (lat != exp_lat(8'h6B, 1'b1) || p_o !== exp_prod(8'hF3, 8'h6B, 1'b1)) begin
            fails++;
            $display("FAIL b2b_second: p=%h lat=%0d, want p=%h lat=%0d",
                     p_o, lat, exp_prod(8'hF3, 8'h6B, 1'b1), exp_lat(8'h6B, 1'b1));
        end
        held = exp_prod(8'hF3, 8'h6B, 1'b1);
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || p_o !== held) begin
                fails++;
                $display("FAIL backpressure_%0d: valid=%b ready=%b p=%h, want 1/0/%h",
                         i, out_valid_o, in_ready_o, p_o, held);
            end
        end
        in_valid_i = 1'b0;
        consume();
        tests_run++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL b2b_drain: valid=%b ready=%b, want 0/1", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_flush();
        int             lat;
        bit             seen;
        logic [2*W-1:0] p;
        a_i = 8'h5A; b_i = 8'hC3; signed_i = 1'b1; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        tests_run++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL flush_busy: valid=%b ready=%b, want 0/1", out_valid_o, in_ready_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid_o) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            fails++;
            $display("FAIL flush_no_valid: out_valid seen=1, want 0");
        end
        run_op(8'h07, 8'hFD, 1'b1, 1'b0, lat, p);
        tests_run++;
        if (p !== 16'hFFEB || lat != exp_lat(8'hFD, 1'b1)) begin
            fails++;
            $display("FAIL flush_next_op: p=%h lat=%0d, want FFEB lat=%0d", p, lat, exp_lat(8'hFD, 1'b1));
        end
        // A flush in DONE beats both out_ready_i and a new accept.
        flush_i = 1'b1; out_ready_i = 1'b1; in_valid_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; out_ready_i = 1'b0; in_valid_i = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL flush_done: valid=%b ready=%b, want 0/1", out_valid_o, in_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        int             lat;
        bit             seen;
        logic [2*W-1:0] p;
        a_i = 8'h33; b_i = 8'h9C; signed_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n_i = 1'b0;
        #1;
        tests_run++;
        if (out_valid_o !== 1'b0 || p_o !== '0) begin
            fails++;
            $display("FAIL reset_mid: valid=%b p=%h, want 0/0000", out_valid_o, p_o);
        end
        #8 rst_n_i = 1'b1;
        tests_run++;
        if (in_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_ready: in_ready=%b, want 1", in_ready_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid_o) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            fails++;
            $display("FAIL reset_mid_no_valid: out_valid seen=1, want 0");
        end
        run_op(8'hC8, 8'h0B, 1'b0, 1'b0, lat, p);
        tests_run++;
        if (p !== exp_prod(8'hC8, 8'h0B, 1'b0) || lat != exp_lat(8'h0B, 1'b0)) begin
            fails++;
            $display("FAIL reset_mid_next_op: p=%h lat=%0d, want p=%h lat=%0d",
                     p, lat, exp_prod(8'hC8, 8'h0B, 1'b0), exp_lat(8'h0B, 1'b0));
        end
        consume();
    endtask

    initial begin
        rst_n_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        signed_i = 1'b0; a_i = '0; b_i = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: operand width; even, >= 4.
REQ-002 SHALL have parameter PP_PER_CYCLE, default 1: radix-4 Booth digits retired per BUSY cycle; legal values 1 or 2.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n_i, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port flush_i, input, 1: synchronous abort of any operation in flight.
REQ-006 SHALL have port in_valid_i, input, 1: operands valid.
REQ-007 SHALL have port in_ready_o, output, 1: block accepts operands.
REQ-008 SHALL have port signed_i, input, 1: 1 = two's-complement operands, 0 = unsigned operands; sampled with the operands.
REQ-009 SHALL have port a_i, input, DATA_WIDTH: multiplicand.
REQ-010 SHALL have port b_i, input, DATA_WIDTH: multiplier (Booth-recoded).
REQ-011 SHALL have port out_valid_o, output, 1: product valid.
REQ-012 SHALL have port out_ready_i, input, 1: consumer takes the product.
REQ-013 SHALL have port p_o, output, 2*DATA_WIDTH: product.

Function
REQ-014 SHALL extend both operands to DATA_WIDTH+2 bits: sign-extend if signed_i=1, zero-extend otherwise; N = DATA_WIDTH/2+1 Booth digits.
REQ-015 SHALL recode each digit from multiplier triple (b2k+1, b2k, b2k-1), with b-1 = 0, to {0, ±1, ±2}; 000 and 111 give 0; 011 gives +2; 100 gives -2.
REQ-016 SHALL add digit*A*4^k into an accumulator of at least 2*DATA_WIDTH+2 bits; negation is one's-complement plus a carry-in; p_o is the low 2*DATA_WIDTH bits.
REQ-017 SHALL implement the FSM IDLE -> BUSY -> DONE.
- IDLE -> BUSY when in_valid_i && in_ready_o; operands are captured and the accumulator is cleared on that edge.
- BUSY retires PP_PER_CYCLE digits per edge; after C = ceil(N/PP_PER_CYCLE) BUSY edges it goes to DONE.
- DONE -> IDLE when out_ready_i=1 and no new accept occurs; DONE -> BUSY when a new accept occurs.
REQ-018 SHALL drive in_ready_o = (state==IDLE) || (state==DONE && out_ready_i); this gives back-to-back operation with no bubble.
REQ-019 SHALL drive out_valid_o = (state==DONE); p_o SHALL hold stable while out_valid_o=1 && out_ready_i=0.
REQ-020 SHALL assert out_valid_o exactly C rising edges after the accepting edge (W=16, P=1: C=9).
REQ-021 SHALL treat in_valid_i as don't-care while in_ready_o=0; operands are not captured.
REQ-022 SHALL make flush_i=1 force IDLE at the next edge from any state, discarding the result, with out_valid_o=0 after that edge; flush_i has priority over accept and over out_ready_i.
REQ-023 SHALL hold p_o at its last value when not in DONE; the value is don't-care for checking.

Reset
REQ-024 SHALL make rst_n_i=0 force, asynchronously: state=IDLE, out_valid_o=0, in_ready_o=1 (once rst_n_i is high), p_o=0, accumulator and operand registers =0.
REQ-025 SHALL abort an operation in flight when reset is asserted mid-operation; no output handshake is produced for it.
REQ-026 SHALL release from reset without producing any spurious out_valid_o pulse.

Configuration
REQ-027 SHALL compile early termination in when macro BOOTH_SEQ_EARLY_TERM_EN is defined.
- After any BUSY edge, if all remaining unprocessed multiplier bits, including the overlap bit, are equal (all 0 or all 1), the FSM SHALL go to DONE immediately.
- Latency is then 1..C edges; the result is identical.
REQ-028 SHALL, without BOOTH_SEQ_EARLY_TERM_EN, use a fixed latency of C edges for all operands, with no early-termination logic present.

Verification (DATA_WIDTH=8, PP_PER_CYCLE=1, C=5 unless noted)
REQ-029 Signed -128 * -128 (a_i=0x80, b_i=0x80, signed_i=1) -> p_o=0x4000, out_valid_o 5 edges after accept.
REQ-030 Unsigned 255*255 (0xFF, 0xFF, signed_i=0) -> p_o=0xFE01; signed -1*-1 with the same bits -> p_o=0x0001.
REQ-031 Back-to-back: second op accepted in the DONE cycle with out_ready_i=1 -> second out_valid_o 5 edges later; out_ready_i held 0 for 3 cycles -> p_o stable, in_ready_o=0.
REQ-032 flush_i pulsed on the 3rd BUSY edge -> IDLE next edge, no out_valid_o; following op 7*-3 signed -> p_o=0xFFEB.
REQ-033 With BOOTH_SEQ_EARLY_TERM_EN: b_i=0x01 unsigned, a_i=0x55 -> p_o=0x0055 after 1 edge; b_i=0xFF signed -> after 1 edge; without the macro both take 5 edges.
REQ-034 rst_n_i asserted mid-BUSY -> outputs at reset values immediately, in_ready_o=1 after release.
